// File: rtl/onehot_decoder_5to32.sv
// Hierarchical 5-to-32 one-hot decoder (2-to-4 group stage, four 3-to-8 stages) plus registered copy.
// Optional ONEHOT_DECODER_CHECK_EN adds a sticky registered one-hot checker output err.

module dec2to4_stage (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);
    always_comb begin
        y = 4'h0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end
endmodule

module dec3to8_stage (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        if (en) begin
            y[sel] = 1'b1;
        end
    end
endmodule

module onehot_decoder_5to32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  in,
    input  logic        enable,
    output logic [31:0] out,
    output logic [31:0] out_q,
`ifdef ONEHOT_DECODER_CHECK_EN
    output logic        err,
`endif
    output logic [3:0]  grp_en
);
    logic [7:0] oct [4];

    dec2to4_stage u_grp (
        .sel (in[4:3]),
        .en  (enable),
        .y   (grp_en)
    );

    // Each octet stage only sees the low select bits; its group enable picks the octet.
    for (genvar k = 0; k < 4; k++) begin : g_oct
        dec3to8_stage u_oct (
            .sel (in[2:0]),
            .en  (grp_en[k]),
            .y   (oct[k])
        );
    end

    assign out = {oct[3], oct[2], oct[1], oct[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 32'h0;
        end else begin
            out_q <= out;
        end
    end

`ifdef ONEHOT_DECODER_CHECK_EN
    logic onehot;
    logic bad;

    assign onehot = (out != 32'h0) && ((out & (out - 32'h1)) == 32'h0);
    assign bad    = enable ? !onehot : (out != 32'h0);

    // Judges the value about to be loaded into out_q; sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!bad)
            else $error("onehot_decoder_5to32: bad decode %h", out);
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decoder_5to32.sv
// Directed self-checking bench for onehot_decoder_5to32.
// Covers reset, full sweep, group boundaries, enable toggle, mid-stream reset (and checker under ONEHOT_DECODER_CHECK_EN).

module tb_onehot_decoder_5to32;
    logic        clk;
    logic        reset;
    logic [4:0]  in;
    logic        enable;
    logic [31:0] out;
    logic [31:0] out_q;
    logic [3:0]  grp_en;
`ifdef ONEHOT_DECODER_CHECK_EN
    logic        err;
`endif

    int tests;
    int fails;

    onehot_decoder_5to32 u_dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out),
        .out_q  (out_q),
`ifdef ONEHOT_DECODER_CHECK_EN
        .err    (err),
`endif
        .grp_en (grp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        in     = 5'd9;
        #1;
        tests++;
        if (out !== 32'h0000_0200) begin
            fails++;
            $display("FAIL reset_out_pre got=%h exp=%h", out, 32'h0000_0200);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (out_q !== 32'h0) begin
                fails++;
                $display("FAIL reset_out_q[%0d] got=%h exp=%h", c, out_q, 32'h0);
            end
            tests++;
            if (out !== 32'h0000_0200) begin
                fails++;
                $display("FAIL reset_out[%0d] got=%h exp=%h", c, out, 32'h0000_0200);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        logic [31:0] exp_o;
        logic [3:0]  exp_g;
        for (int i = 0; i < 32; i++) begin
            exp_o  = 32'h1 << i;
            exp_g  = 4'h1 << (i >> 3);
            enable = 1'b0;
            in     = 5'(i);
            #1;
            tests++;
            if (out !== 32'h0 || grp_en !== 4'h0) begin
                fails++;
                $display("FAIL sweep_dis in=%0d out=%h grp=%b exp=0/0", i, out, grp_en);
            end
            tick();
            tests++;
            if (out_q !== 32'h0) begin
                fails++;
                $display("FAIL sweep_dis_q in=%0d got=%h exp=0", i, out_q);
            end
            enable = 1'b1;
            #1;
            tests++;
            if (out !== exp_o || grp_en !== exp_g) begin
                fails++;
                $display("FAIL sweep_en in=%0d out=%h grp=%b exp=%h/%b",
                         i, out, grp_en, exp_o, exp_g);
            end
            tick();
            tests++;
            if (out_q !== exp_o) begin
                fails++;
                $display("FAIL sweep_en_q in=%0d got=%h exp=%h", i, out_q, exp_o);
            end
        end
    endtask

    task automatic test_groups();
        logic [4:0]  vin [4];
        logic [31:0] vo  [4];
        logic [3:0]  vg  [4];
        vin = '{5'd7, 5'd8, 5'd23, 5'd24};
        vo  = '{32'h0000_0080, 32'h0000_0100, 32'h0080_0000, 32'h0100_0000};
        vg  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in = vin[k];
            #1;
            tests++;
            if (out !== vo[k] || grp_en !== vg[k]) begin
                fails++;
                $display("FAIL group in=%0d out=%h grp=%b exp=%h/%b",
                         vin[k], out, grp_en, vo[k], vg[k]);
            end
            tick();
        end
    endtask

    task automatic test_enable_toggle();
        logic        ve [3];
        logic [31:0] vo [3];
        ve = '{1'b1, 1'b0, 1'b1};
        vo = '{32'h8000_0000, 32'h0, 32'h8000_0000};
        in = 5'd31;
        for (int k = 0; k < 3; k++) begin
            enable = ve[k];
            #1;
            tests++;
            if (out !== vo[k]) begin
                fails++;
                $display("FAIL toggle_out[%0d] got=%h exp=%h", k, out, vo[k]);
            end
            tick();
            tests++;
            if (out_q !== vo[k]) begin
                fails++;
                $display("FAIL toggle_q[%0d] got=%h exp=%h", k, out_q, vo[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_q;
        enable = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in    = 5'(j);
            reset = (j == 3);
            #1;
            if (j == 3) begin
                tests++;
                if (out_q !== 32'h0000_0004) begin
                    fails++;
                    $display("FAIL rst_async got=%h exp=%h", out_q, 32'h4);
                end
                tests++;
                if (out !== 32'h0000_0008) begin
                    fails++;
                    $display("FAIL rst_out got=%h exp=%h", out, 32'h8);
                end
            end
            tick();
            exp_q = (j == 3) ? 32'h0 : (32'h1 << j);
            tests++;
            if (out_q !== exp_q) begin
                fails++;
                $display("FAIL rst_mid_q[%0d] got=%h exp=%h", j, out_q, exp_q);
            end
        end
        reset = 1'b0;
    endtask

`ifdef ONEHOT_DECODER_CHECK_EN
    task automatic test_checker();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in     = 5'(i % 32);
            enable = (i >= 32);
            tick();
        end
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL chk_clean got=%b exp=0", err);
        end
        enable = 1'b1;
        force u_dut.out = 32'h3;
        tick();
        release u_dut.out;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL chk_set got=%b exp=1", err);
        end
        tick();
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL chk_sticky got=%b exp=1", err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL chk_clear got=%b exp=0", err);
        end
    endtask
`endif

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        enable = 1'b0;
        in     = 5'd0;
        test_reset();
        test_sweep();
        test_groups();
        test_enable_toggle();
        test_reset_mid();
`ifdef ONEHOT_DECODER_CHECK_EN
        test_checker();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
